// File: rtl/dual_alu_lockstep.sv
// -----------------------------------------------------------------------------
// dual_alu_lockstep
//
// Purpose:
//   Two independent registered ALUs plus a comparator that flags every
//   per-bit result difference and any carry difference between them. Used as
//   a redundancy / lockstep checker: feeding both ALUs the same stimulus must
//   keep x == 0 and y == 0.
//
//   Each ALU supports four opcodes:
//     00 ADD
//     01 SUB (borrow is reported on the carry output)
//     10 AND
//     11 XOR
//
//   All results are registered, giving a latency of one cycle. A new
//   operation is accepted on every clock.
//
// Ports:
//   clk                   single clock; all state updates on the rising edge
//   rst                   synchronous, active-high reset; clears every output
//   a0, b0, alu_sel1      ALU1 operands and opcode
//   a1, b1, alu_sel2      ALU2 operands and opcode
//   alu_out1, carry_out1  ALU1 registered result and carry/borrow
//   alu_out2, carry_out2  ALU2 registered result and carry/borrow
//   x                     registered result mismatch vector (res1 ^ res2)
//   y                     registered carry mismatch (c1 ^ c2)
//   err_sticky            sticky mismatch flag
//
// Configuration:
//   ALU_MISMATCH_STICKY_EN
//     When defined, err_sticky latches high at any edge where the registered
//     x is non-zero or the registered y is set. It stays high until rst.
//     When undefined, err_sticky is tied to 0 and no flop is built for it.
// -----------------------------------------------------------------------------
module dual_alu_lockstep #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] b0,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] b1,
  input  logic [1:0]       alu_sel1,
  input  logic [1:0]       alu_sel2,
  output logic [WIDTH-1:0] alu_out1,
  output logic [WIDTH-1:0] alu_out2,
  output logic             carry_out1,
  output logic             carry_out2,
  output logic [WIDTH-1:0] x,
  output logic             y,
  output logic             err_sticky
);

  // One ALU evaluation. The result is returned as {carry, result}.
  function automatic logic [WIDTH:0] alu_calc(
    input logic [1:0]       sel,
    input logic [WIDTH-1:0] a,
    input logic [WIDTH-1:0] b
  );
    logic [WIDTH:0] r;
    case (sel)
      2'b00:   r = {1'b0, a} + {1'b0, b};
      // The borrow is the unsigned compare. It is not the sum's MSB.
      2'b01:   r = {(a < b), a - b};
      2'b10:   r = {1'b0, a & b};
      2'b11:   r = {1'b0, a ^ b};
      default: r = {(WIDTH+1){1'b0}};
    endcase
    return r;
  endfunction

  logic [WIDTH:0] full1_s;
  logic [WIDTH:0] full2_s;

  // Combinational evaluation of both ALUs on this cycle's inputs.
  always_comb begin
    full1_s = {(WIDTH+1){1'b0}};
    full2_s = {(WIDTH+1){1'b0}};
    full1_s = alu_calc(alu_sel1, a0, b0);
    full2_s = alu_calc(alu_sel2, a1, b1);
  end

  // Result, carry and comparator registers; all of them update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      alu_out1   <= {WIDTH{1'b0}};
      alu_out2   <= {WIDTH{1'b0}};
      carry_out1 <= 1'b0;
      carry_out2 <= 1'b0;
      x          <= {WIDTH{1'b0}};
      y          <= 1'b0;
    end else begin
      alu_out1   <= full1_s[WIDTH-1:0];
      alu_out2   <= full2_s[WIDTH-1:0];
      carry_out1 <= full1_s[WIDTH];
      carry_out2 <= full2_s[WIDTH];
      // The comparator works on the unregistered results so that it lines
      // up in time with the outputs it describes.
      x          <= full1_s[WIDTH-1:0] ^ full2_s[WIDTH-1:0];
      y          <= full1_s[WIDTH] ^ full2_s[WIDTH];
    end
  end

`ifdef ALU_MISMATCH_STICKY_EN
  logic err_sticky_r;

  // Sticky flag. It looks at the already-registered comparator outputs, so
  // it rises one edge after x/y show a mismatch. Reset has priority.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_sticky_r <= 1'b0;
    end else if ((x != {WIDTH{1'b0}}) || y) begin
      err_sticky_r <= 1'b1;
    end else begin
      err_sticky_r <= err_sticky_r;
    end
  end

  assign err_sticky = err_sticky_r;
`else
  assign err_sticky = 1'b0;
`endif

endmodule

// File: tb/tb_dual_alu_lockstep.sv
// -----------------------------------------------------------------------------
// Testbench for dual_alu_lockstep.
//
// Directed scenarios are checked against hand-derived constants. Random
// back-to-back traffic is checked against an integer-arithmetic reference
// model.
// -----------------------------------------------------------------------------
module tb_dual_alu_lockstep;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] a0, b0, a1, b1;
  logic [1:0] alu_sel1, alu_sel2;
  logic [7:0] alu_out1, alu_out2, x;
  logic       carry_out1, carry_out2, y, err_sticky;

  int vectors = 0;
  int miscompares = 0;

  // Model state: the expected packed view and the expected sticky flag
  // after the most recent edge.
  logic [26:0] exp_pk = 27'h0;
  logic        exp_sticky = 1'b0;

  dual_alu_lockstep #(.WIDTH(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .a0         (a0),
    .b0         (b0),
    .a1         (a1),
    .b1         (b1),
    .alu_sel1   (alu_sel1),
    .alu_sel2   (alu_sel2),
    .alu_out1   (alu_out1),
    .alu_out2   (alu_out2),
    .carry_out1 (carry_out1),
    .carry_out2 (carry_out2),
    .x          (x),
    .y          (y),
    .err_sticky (err_sticky)
  );

  always #5 clk = ~clk;

  // Packed pad view: {y, x, carry_out2, carry_out1, alu_out2, alu_out1}.
  function automatic logic [26:0] got_pk();
    return {y, x, carry_out2, carry_out1, alu_out2, alu_out1};
  endfunction

  // Reference ALU built from plain integer arithmetic.
  // The return value is carry * 256 + result.
  function automatic int ref_alu(input int op, input int a, input int b);
    int s;
    case (op)
      0:       begin s = a + b; return s; end                 // 9-bit sum
      1:       return (a < b) ? (256 + a - b + 256) : (a - b); // borrow -> bit 8
      2:       return a & b;
      default: return a ^ b;
    endcase
  endfunction

  // Drive one cycle, advance the model, then settle 1 time unit after the
  // edge so that the outputs can be sampled.
  task automatic drive(input logic r,
                       input logic [7:0] ia0, input logic [7:0] ib0,
                       input logic [7:0] ia1, input logic [7:0] ib1,
                       input logic [1:0] s1, input logic [1:0] s2);
    int v1, v2, r1, r2, c1, c2;
    rst = r; a0 = ia0; b0 = ib0; a1 = ia1; b1 = ib1;
    alu_sel1 = s1; alu_sel2 = s2;
    v1 = ref_alu(int'(s1), int'(ia0), int'(ib0));
    v2 = ref_alu(int'(s2), int'(ia1), int'(ib1));
    r1 = v1 % 256; c1 = (v1 / 256) % 2;
    r2 = v2 % 256; c2 = (v2 / 256) % 2;
    @(posedge clk);
`ifdef ALU_MISMATCH_STICKY_EN
    exp_sticky = r ? 1'b0 : (exp_sticky | (exp_pk[26:18] != 9'd0));
`else
    exp_sticky = 1'b0;
`endif
    if (r) begin
      exp_pk = 27'h0;
    end else begin
      exp_pk = {(c1 != c2), 8'(r1 ^ r2), 1'(c2), 1'(c1), 8'(r2), 8'(r1)};
    end
    #1;
  endtask

  task automatic test_reset();
    drive(1'b1, 8'hA5, 8'h5A, 8'h33, 8'hCC, 2'b00, 2'b01);
    drive(1'b1, 8'hFF, 8'h01, 8'h00, 8'h01, 2'b00, 2'b01);
    vectors++;
    if (got_pk() !== 27'h0) begin
      $display("FAIL reset_outputs got=%h exp=%h", got_pk(), 27'h0);
      miscompares++;
    end
    vectors++;
    if (err_sticky !== 1'b0) begin
      $display("FAIL reset_sticky got=%b exp=0", err_sticky);
      miscompares++;
    end
    // Release: 0x10+0x20=0x30 vs 0x10^0x20=0x30, so x=0 and y=0.
    drive(1'b0, 8'h10, 8'h20, 8'h10, 8'h20, 2'b00, 2'b11);
    vectors++;
    if (got_pk() !== {1'b0, 8'h00, 1'b0, 1'b0, 8'h30, 8'h30}) begin
      $display("FAIL reset_release got=%h exp=%h", got_pk(),
               {1'b0, 8'h00, 1'b0, 1'b0, 8'h30, 8'h30});
      miscompares++;
    end
  endtask

  task automatic test_add();
    drive(1'b0, 8'h81, 8'h81, 8'h00, 8'h00, 2'b00, 2'b00);
    vectors++;
    if (got_pk() !== 27'h4090002) begin
      $display("FAIL add_packed got=%h exp=%h", got_pk(), 27'h4090002);
      miscompares++;
    end
    // 0xFF + 0x01 wraps to 0x00 with carry set, in both ALUs.
    drive(1'b0, 8'hFF, 8'h01, 8'hFF, 8'h01, 2'b00, 2'b00);
    vectors++;
    if (got_pk() !== {1'b0, 8'h00, 1'b1, 1'b1, 8'h00, 8'h00}) begin
      $display("FAIL add_wrap got=%h exp=%h", got_pk(),
               {1'b0, 8'h00, 1'b1, 1'b1, 8'h00, 8'h00});
      miscompares++;
    end
  endtask

  task automatic test_sub();
    drive(1'b0, 8'h3C, 8'h0F, 8'h3C, 8'h0F, 2'b01, 2'b01);
    vectors++;
    if (got_pk() !== {1'b0, 8'h00, 1'b0, 1'b0, 8'h2D, 8'h2D}) begin
      $display("FAIL sub_nob got=%h exp=%h", got_pk(),
               {1'b0, 8'h00, 1'b0, 1'b0, 8'h2D, 8'h2D});
      miscompares++;
    end
    drive(1'b0, 8'h01, 8'h02, 8'h01, 8'h02, 2'b01, 2'b01);
    vectors++;
    if (got_pk() !== {1'b0, 8'h00, 1'b1, 1'b1, 8'hFF, 8'hFF}) begin
      $display("FAIL sub_borrow got=%h exp=%h", got_pk(),
               {1'b0, 8'h00, 1'b1, 1'b1, 8'hFF, 8'hFF});
      miscompares++;
    end
    // Equal operands give 0 with no borrow.
    drive(1'b0, 8'h80, 8'h80, 8'h80, 8'h7F, 2'b01, 2'b01);
    vectors++;
    if (got_pk() !== {1'b0, 8'h01, 1'b0, 1'b0, 8'h01, 8'h00}) begin
      $display("FAIL sub_equal got=%h exp=%h", got_pk(),
               {1'b0, 8'h01, 1'b0, 1'b0, 8'h01, 8'h00});
      miscompares++;
    end
  endtask

  task automatic test_mixed();
    drive(1'b0, 8'hF0, 8'h3C, 8'hF0, 8'h3C, 2'b10, 2'b11);
    vectors++;
    if (got_pk() !== {1'b0, 8'hFC, 1'b0, 1'b0, 8'hCC, 8'h30}) begin
      $display("FAIL mixed_and_xor got=%h exp=%h", got_pk(),
               {1'b0, 8'hFC, 1'b0, 1'b0, 8'hCC, 8'h30});
      miscompares++;
    end
    // SUB with borrow on ALU1 against ADD on ALU2.
    // ALU1: 0x00-0x01 = 0xFF, c=1. ALU2: 0x00+0x01 = 0x01, c=0.
    drive(1'b0, 8'h00, 8'h01, 8'h00, 8'h01, 2'b01, 2'b00);
    vectors++;
    if (got_pk() !== {1'b1, 8'hFE, 1'b0, 1'b1, 8'h01, 8'hFF}) begin
      $display("FAIL mixed_sub_add got=%h exp=%h", got_pk(),
               {1'b1, 8'hFE, 1'b0, 1'b1, 8'h01, 8'hFF});
      miscompares++;
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 300; i++) begin
      drive(($urandom_range(0, 29) == 0) ? 1'b1 : 1'b0,
            8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
            2'($urandom), 2'($urandom));
      vectors++;
      if (got_pk() !== exp_pk) begin
        $display("FAIL b2b_%0d got=%h exp=%h", i, got_pk(), exp_pk);
        miscompares++;
      end
      vectors++;
      if (err_sticky !== exp_sticky) begin
        $display("FAIL b2b_sticky_%0d got=%b exp=%b", i, err_sticky, exp_sticky);
        miscompares++;
      end
    end
    // Reset asserted mid-stream, with operands still active, gives zeros on that edge.
    drive(1'b0, 8'h81, 8'h81, 8'h00, 8'h00, 2'b00, 2'b00);
    drive(1'b1, 8'h81, 8'h81, 8'h00, 8'h00, 2'b00, 2'b00);
    vectors++;
    if (got_pk() !== 27'h0 || err_sticky !== 1'b0) begin
      $display("FAIL b2b_midreset got=%h/%b exp=0/0", got_pk(), err_sticky);
      miscompares++;
    end
  endtask

  task automatic test_sticky();
    logic s_exp;
    drive(1'b1, 8'h00, 8'h00, 8'h00, 8'h00, 2'b00, 2'b00);
    drive(1'b0, 8'h01, 8'h00, 8'h02, 8'h00, 2'b00, 2'b00); // single mismatching cycle
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 8'h55, 8'h11, 8'h55, 8'h11, 2'b11, 2'b11);
`ifdef ALU_MISMATCH_STICKY_EN
      s_exp = 1'b1;
`else
      s_exp = 1'b0;
`endif
      vectors++;
      if (err_sticky !== s_exp) begin
        $display("FAIL sticky_hold_%0d got=%b exp=%b", i, err_sticky, s_exp);
        miscompares++;
      end
    end
    // Reset wins even while the flag is set.
    drive(1'b1, 8'h01, 8'h00, 8'h02, 8'h00, 2'b00, 2'b00);
    vectors++;
    if (err_sticky !== 1'b0) begin
      $display("FAIL sticky_clear got=%b exp=0", err_sticky);
      miscompares++;
    end
  endtask

  initial begin
    rst = 1'b1; a0 = 8'h0; b0 = 8'h0; a1 = 8'h0; b1 = 8'h0;
    alu_sel1 = 2'b00; alu_sel2 = 2'b00;
    test_reset();
    test_add();
    test_sub();
    test_mixed();
    test_back_to_back();
    test_sticky();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
